// File: rtl/seq_add_sub.sv
// seq_add_sub: digit-serial add/subtract unit.
// Processes a WIDTH-bit add or subtract DIGIT bits per clock behind a
// start/busy/done handshake. Returns the sum, the carry out of the MSB and
// the signed overflow.
// Ports:
//   clk_i    clock, all state changes on the rising edge
//   rst_i    synchronous reset, active-high
//   start_i  request; sampled only in IDLE or DONE
//   a_i      operand A (captured on accept)
//   b_i      operand B (captured on accept)
//   cin_i    carry/borrow in (captured on accept)
//   sub_i    0: a+b+cin, 1: a-b-cin (captured on accept)
//   busy_o   high while an operation is running
//   done_o   one-cycle pulse when sum_o/cout_o/ovf_o are updated
//   sum_o    result, held until the next completion
//   cout_o   carry out of the MSB (subtract: 1 = no borrow)
//   ovf_o    signed overflow
module seq_add_sub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  // Operands must split into whole digits.
  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("seq_add_sub: WIDTH must be a multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;       // B already conditioned for subtract
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] part_q, part_d; // partial result, never on the outputs
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [IDX_W-1:0] base;
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;
  logic             msb_cin;        // carry into the top bit of this digit

  // Ripple-add the current digit slice with the running carry.
  always_comb begin : digit_add
    logic c;
    c        = carry_q;
    msb_cin  = carry_q;
    dig_sum  = '0;
    base     = IDX_W'(cnt_q) * IDX_W'(DIGIT);
    a_dig    = a_q[base +: DIGIT];
    b_dig    = b_q[base +: DIGIT];
    for (int i = 0; i < int'(DIGIT); i++) begin
      msb_cin    = c;
      dig_sum[i] = a_dig[i] ^ b_dig[i] ^ c;
      c          = (a_dig[i] & b_dig[i]) | (c & (a_dig[i] ^ b_dig[i]));
    end
    dig_cout = c;
  end

  // Next-state and output logic.
  always_comb begin : next_state
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    part_d  = part_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          // Subtract as A + ~B + ~cin so one adder serves both operations.
          state_d = S_RUN;
          a_d     = a_i;
          b_d     = b_i ^ {WIDTH{sub_i}};
          carry_d = cin_i ^ sub_i;
          cnt_d   = '0;
          part_d  = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        part_d[base +: DIGIT] = dig_sum;
        carry_d               = dig_cout;
        if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          sum_d   = part_d;
          cout_d  = dig_cout;
          ovf_d   = dig_cout ^ msb_cin;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          busy_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      part_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;

endmodule
